// File: rtl/dsram_pkg.sv
// Shared types and constants for the data SRAM slave: transfer size codes,
// the response queue entry layout and the stall LFSR seed/taps.
package dsram_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Countdown width covers LATENCY-1 for LATENCY up to 7
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [31:0]      rdata;
    logic             is_wr;
    logic [CNT_W-1:0] cnt;
  } dsram_entry_t;

  // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dsram_resp_fifo.sv
// In-order response queue for the data SRAM slave. Holds up to OUTST
// accepted requests, counts each one down from LATENCY-1 and flags the head
// once its countdown has expired.
module dsram_resp_fifo
  import dsram_pkg::*;
#(
  parameter int OUTST   = 2,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push_i,
  input  dsram_entry_t push_entry_i,
  input  logic         pop_i,
  output logic [2:0]   count_o,
  output dsram_entry_t head_o,
  output logic         head_ready_o
);

  localparam int               PTR_W    = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTST - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  dsram_entry_t     entry_q [OUTST];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [2:0]       count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointers and occupancy; simultaneous push and pop leaves count as is
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = ptr_inc(tail_q);
    if (pop_i)  head_d = ptr_inc(head_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the queue and drops anything in flight
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: every live countdown ticks, a push overwrites the tail slot
  always_ff @(posedge clk) begin
    for (int i = 0; i < OUTST; i++) begin
      if (entry_q[i].cnt != '0) entry_q[i].cnt <= entry_q[i].cnt - CNT_W'(1);
    end
    if (push_i) begin
      entry_q[tail_q].rdata <= push_entry_i.rdata;
      entry_q[tail_q].is_wr <= push_entry_i.is_wr;
      entry_q[tail_q].cnt   <= CNT_INIT;
    end
  end

  assign count_o      = count_q;
  assign head_o       = entry_q[head_q];
  assign head_ready_o = (count_q != 3'd0) && (entry_q[head_q].cnt == '0);

endmodule

// File: rtl/data_sram_slave.sv
// Data SRAM-like bus responder with fixed-latency, in-order responses.
// Owns the backing store, the req/addr_ok handshake and the byte-lane
// write merge; response timing lives in dsram_resp_fifo.
// Optional build macro DSRAM_RAND_STALL_EN adds LFSR-driven random stalls
// on both accept and response; without it timing is fully deterministic.
module data_sram_slave
  import dsram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 14,
  parameter int LATENCY    = 1,
  parameter int OUTST      = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [31:0]           mem_q [WORDS];
  logic                  resetn_q;
  logic [DEPTH_LOG2-1:0] widx;
  logic [31:0]           rd_word;
  logic                  accept;
  logic                  stall_acc;
  logic                  stall_rsp;
  logic [2:0]            count;
  logic                  head_ready;
  dsram_entry_t          head;
  dsram_entry_t          push_entry;

`ifdef DSRAM_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Free-running stall source, advances every cycle
  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // LFSR state, restarted from the fixed seed on reset
  always_ff @(posedge clk) begin
    if (!resetn) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign stall_acc = ~lfsr_q[0];
  assign stall_rsp = ~lfsr_q[1];
`else
  assign stall_acc = 1'b0;
  assign stall_rsp = 1'b0;
`endif

  // Delayed reset keeps addr_ok low for the first cycle after release
  always_ff @(posedge clk) begin
    resetn_q <= resetn;
  end

  // No bypass: a full queue refuses even while its head is retiring
  assign addr_ok = resetn_q & (count < 3'(OUTST)) & ~stall_acc;
  assign accept  = req & addr_ok & resetn;

  // Upper address bits alias, byte offset is ignored
  assign widx    = addr[DEPTH_LOG2+1:2];
  assign rd_word = mem_q[widx];

  // Byte-lane merge on the accept edge; memory contents survive reset
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read data is captured before any later write, giving read-after-write order
  always_comb begin
    push_entry       = '0;
    push_entry.rdata = rd_word;
    push_entry.is_wr = wr;
  end

  dsram_resp_fifo #(
    .OUTST   (OUTST),
    .LATENCY (LATENCY)
  ) u_resp_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push_i       (accept),
    .push_entry_i (push_entry),
    .pop_i        (data_ok),
    .count_o      (count),
    .head_o       (head),
    .head_ready_o (head_ready)
  );

  // Response comes only from queue state, so it never follows req combinationally
  assign data_ok = head_ready & ~stall_rsp;
  assign rdata   = (data_ok && !head.is_wr) ? head.rdata : 32'h0;

  // Size code and aliased address bits carry no function here
  logic unused_bits;
  assign unused_bits = ^{size == SIZE_BYTE, size == SIZE_HALF, size == SIZE_WORD,
                         addr[31:DEPTH_LOG2+2], addr[1:0]};

endmodule

// File: doc/data_sram_slave.md
Name: data_sram_slave

Overview:
- Responder end of the core's data SRAM-like bus; the memory that EX-stage requests target and whose rdata the MEM stage consumes.
- Accepts read and write requests with a req/addr_ok handshake and returns in-order responses with data_ok/rdata after a fixed latency.
- Used as the data memory in the simulation top, replacing the ideal zero-wait SRAM so the pipeline can run with multi-cycle memory.

Parameters:
- DEPTH_LOG2, 14: log2 of the word count; backing store is 2^DEPTH_LOG2 x 32 bits.
- LATENCY, 1: cycles from the accept edge to data_ok; legal range 1..7.
- OUTST, 2: maximum accepted-but-unanswered requests; legal range 1..4.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- req  in  1  request valid
- wr  in  1  1 = write, 0 = read
- size  in  2  0 = byte, 1 = half, 2 = word; informational only
- addr  in  32  byte address
- wstrb  in  4  byte write enables; used only when wr=1
- wdata  in  32  write data
- addr_ok  out  1  request accepted this cycle when req & addr_ok
- data_ok  out  1  one-cycle response pulse
- rdata  out  32  read data; valid only while data_ok=1

Behaviour:
- Clock and reset: clk is the clock. resetn is synchronous, active-low.
- Reset values: addr_ok=0, data_ok=0, rdata=0, response queue empty, occupancy count=0.
  - Memory array is not cleared by reset.
- Accept: a request is accepted on a rising edge where req & addr_ok = 1.
- addr_ok = resetn_q & (count < OUTST).
  - resetn_q is resetn registered once, so addr_ok is 0 in the first cycle after reset release.
  - There is no same-cycle bypass for a retiring entry: if count == OUTST, addr_ok = 0 even if data_ok retires an entry that cycle.
- Addressing: word index = addr[DEPTH_LOG2+1:2]. Higher bits are ignored (aliasing/wrap). addr[1:0] is ignored.
- Write: on the accept edge, each byte i with wstrb[i]=1 takes wdata[8i+7:8i]; other bytes are unchanged.
  - wstrb = 0 is a legal no-op write that still gets a response.
- Read: the word is sampled combinationally at the accept edge and stored in the queue entry.
  - This gives read-after-write ordering: a read accepted after a write always returns the post-write value.
- Queue: circular FIFO of OUTST entries. Each entry holds {rdata[31:0], cnt[2:0]}.
  - On push, cnt = LATENCY-1.
  - Every entry with cnt>0 decrements by 1 each cycle.
- Response: data_ok = 1 when the queue is non-empty and head.cnt == 0 and that entry has been resident at least one edge. data_ok is registered, never combinational from req.
  - rdata = head.rdata for reads, 32'h0 for writes.
  - The requester must take the response; there is no back-pressure. The head is popped in the same cycle data_ok=1.
- Order and latency: responses are strictly in accept order. With LATENCY=L and no queueing, data_ok is seen L cycles after the accept edge.
- Simultaneous accept and retire: count is unchanged; head and tail pointers both advance and wrap mod OUTST.
- Back-to-back: with OUTST >= LATENCY+1 the block sustains 1 request/cycle.
- Reset mid-operation: all in-flight responses are dropped (no data_ok after reset). Writes accepted before reset persist.

Optional Feature:
- Macro: DSRAM_RAND_STALL_EN.
- With DSRAM_RAND_STALL_EN:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to 16'hACE1, steps every cycle.
  - addr_ok is additionally ANDed with lfsr[0].
  - A head entry with cnt==0 is held (data_ok=0) while lfsr[1]==0.
  - Ordering and data rules are unchanged.
- Without it: fully deterministic timing as above; the LFSR logic is absent.

Decomposition:
- Shared package dsram_pkg:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
  - Queue entry typedef {rdata, is_wr, cnt}.
  - LFSR seed and tap constants.
- One sub-module, dsram_resp_fifo: occupancy count, pointers, per-entry countdown, head-ready output.
- The top keeps the memory array, the handshake and the write merge.

Test Plan:
- Write/read, LATENCY=1: write addr=0x100, wstrb=4'hF, wdata=0xDEADBEEF, then read 0x100 → write gets data_ok with rdata=0; read gets data_ok 1 cycle after its accept with rdata=0xDEADBEEF.
- Byte merge: word 0x200=0x11223344, then write wstrb=4'b0010, wdata=0x0000AA00, then read → 0x1122AA44.
- Back-pressure, OUTST=2, LATENCY=3: hold req high for 4 cycles → addr_ok drops after 2 accepts; data_ok at accept+3; 3rd accept only after the first retire; 4 responses in order.
- RAW in flight: write 0x300=0x5 and read 0x300 on consecutive cycles → read returns 0x5.
- Reset mid-flight: accept a read, assert resetn=0 before data_ok → no data_ok at any time after; addr_ok=0 in the first cycle after release; earlier writes are still readable.
- Aliasing, DEPTH_LOG2=14: write 0x10000 with data 0x77, read 0x0 → 0x77.
